// File: rtl/l1_miss_arbiter.sv
// Transaction-locked arbiter sharing the L1->L2 txrx buffer port between L1I and L1D.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: L1I fixed priority).
module l1_miss_arbiter #(
    parameter int BLOCK_WORDS = 16,
    parameter int CNT_W       = $clog2(BLOCK_WORDS) + 1
) (
    input  logic        clock_i,
    input  logic        reset_i,

    input  logic        l1i_req_i,
    input  logic        l1i_reqBlock_i,
    input  logic        l1i_rw_i,
    input  logic        l1i_write_i,
    input  logic        l1i_read_i,
    input  logic [23:0] l1i_add_i,
    input  logic [31:0] l1i_data_i,
    output logic        l1i_uc_en_o,
    output logic        l1i_uc_write_ready_o,
    output logic        l1i_uc_read_ready_o,
    output logic [31:0] l1i_uc_data_o,

    input  logic        l1d_req_i,
    input  logic        l1d_reqBlock_i,
    input  logic        l1d_rw_i,
    input  logic        l1d_write_i,
    input  logic        l1d_read_i,
    input  logic [23:0] l1d_add_i,
    input  logic [31:0] l1d_data_i,
    output logic        l1d_uc_en_o,
    output logic        l1d_uc_write_ready_o,
    output logic        l1d_uc_read_ready_o,
    output logic [31:0] l1d_uc_data_o,

    output logic        buf_req_o,
    output logic        buf_reqBlock_o,
    output logic        buf_rw_o,
    output logic        buf_write_en_o,
    output logic        buf_read_ack_o,
    output logic [23:0] buf_add_o,
    output logic [31:0] buf_data_o,
    input  logic        buf_ready_write_i,
    input  logic        buf_ready_read_i,
    input  logic [31:0] buf_data_i,

    output logic [1:0]  grant_o,
    output logic        abort_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN
    } state_t;

    state_t           r_state, w_nextState;
    logic [1:0]       r_grant, w_nextGrant;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_target;
    logic             r_abort;

    logic             w_selD;
    logic             w_busy;
    logic             w_gReq, w_gRw, w_gWrite, w_gRead;
    logic             w_beat, w_done, w_abort;
    logic             w_pickD, w_winBlock, w_start;
    logic [CNT_W-1:0] w_countInc;

    assign w_selD   = r_grant[1];
    assign w_busy   = (r_state == S_BUSY);
    assign w_gReq   = w_selD ? l1d_req_i   : l1i_req_i;
    assign w_gRw    = w_selD ? l1d_rw_i    : l1i_rw_i;
    assign w_gWrite = w_selD ? l1d_write_i : l1i_write_i;
    assign w_gRead  = w_selD ? l1d_read_i  : l1i_read_i;

    assign w_beat     = w_busy & (w_gRw ? (w_gWrite & buf_ready_write_i)
                                        : (w_gRead  & buf_ready_read_i));
    assign w_countInc = r_count + 1'b1;
    assign w_done     = w_beat & (w_countInc == r_target);
    // A final beat coinciding with a dropped request is a normal completion.
    assign w_abort    = w_busy & ~w_done & ~w_gReq;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastD;
    assign w_pickD = l1d_req_i & (~l1i_req_i | ~r_lastD);
`else
    assign w_pickD = l1d_req_i & ~l1i_req_i;
`endif

    assign w_winBlock = w_pickD ? l1d_reqBlock_i : l1i_reqBlock_i;
    assign w_start    = (r_state == S_IDLE) & (l1i_req_i | l1d_req_i);

    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nextState = S_BUSY;
                    w_nextGrant = w_pickD ? 2'b10 : 2'b01;
                end
            end
            S_BUSY: begin
                if (w_done || w_abort) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_nextState = S_IDLE;
                w_nextGrant = 2'b00;
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextGrant = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_nextGrant;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_count  <= '0;
            r_target <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_start) begin
                r_count  <= '0;
                r_target <= w_winBlock ? CNT_W'(BLOCK_WORDS) : CNT_W'(1);
            end else if (w_done || w_abort) begin
                r_count <= '0;
            end else if (w_beat) begin
                r_count <= w_countInc;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset to "L1D served last" so the first tie goes to L1I.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_lastD <= 1'b1;
        end else if (w_start) begin
            r_lastD <= w_pickD;
        end
    end
`endif

    always_comb begin
        buf_req_o            = 1'b0;
        buf_reqBlock_o       = 1'b0;
        buf_rw_o             = 1'b0;
        buf_write_en_o       = 1'b0;
        buf_read_ack_o       = 1'b0;
        buf_add_o            = '0;
        buf_data_o           = '0;
        l1i_uc_en_o          = 1'b1;
        l1i_uc_write_ready_o = 1'b0;
        l1i_uc_read_ready_o  = 1'b0;
        l1i_uc_data_o        = '0;
        l1d_uc_en_o          = 1'b1;
        l1d_uc_write_ready_o = 1'b0;
        l1d_uc_read_ready_o  = 1'b0;
        l1d_uc_data_o        = '0;
        if (w_busy) begin
            if (w_selD) begin
                buf_req_o            = l1d_req_i;
                buf_reqBlock_o       = l1d_reqBlock_i;
                buf_rw_o             = l1d_rw_i;
                buf_write_en_o       = l1d_write_i;
                buf_read_ack_o       = l1d_read_i;
                buf_add_o            = l1d_add_i;
                buf_data_o           = l1d_data_i;
                l1i_uc_en_o          = 1'b0;
                l1d_uc_write_ready_o = buf_ready_write_i;
                l1d_uc_read_ready_o  = buf_ready_read_i;
                l1d_uc_data_o        = buf_data_i;
            end else begin
                buf_req_o            = l1i_req_i;
                buf_reqBlock_o       = l1i_reqBlock_i;
                buf_rw_o             = l1i_rw_i;
                buf_write_en_o       = l1i_write_i;
                buf_read_ack_o       = l1i_read_i;
                buf_add_o            = l1i_add_i;
                buf_data_o           = l1i_data_i;
                l1d_uc_en_o          = 1'b0;
                l1i_uc_write_ready_o = buf_ready_write_i;
                l1i_uc_read_ready_o  = buf_ready_read_i;
                l1i_uc_data_o        = buf_data_i;
            end
        end
    end

    assign grant_o = r_grant;
    assign abort_o = r_abort;

endmodule

// File: tb/tb_l1_miss_arbiter.sv
// Directed, table-driven bench for l1_miss_arbiter; the tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_l1_miss_arbiter;

    logic        clock_i, reset_i;
    logic        l1i_req_i, l1i_reqBlock_i, l1i_rw_i, l1i_write_i, l1i_read_i;
    logic [23:0] l1i_add_i;
    logic [31:0] l1i_data_i;
    logic        l1i_uc_en_o, l1i_uc_write_ready_o, l1i_uc_read_ready_o;
    logic [31:0] l1i_uc_data_o;
    logic        l1d_req_i, l1d_reqBlock_i, l1d_rw_i, l1d_write_i, l1d_read_i;
    logic [23:0] l1d_add_i;
    logic [31:0] l1d_data_i;
    logic        l1d_uc_en_o, l1d_uc_write_ready_o, l1d_uc_read_ready_o;
    logic [31:0] l1d_uc_data_o;
    logic        buf_req_o, buf_reqBlock_o, buf_rw_o, buf_write_en_o, buf_read_ack_o;
    logic [23:0] buf_add_o;
    logic [31:0] buf_data_o;
    logic        buf_ready_write_i, buf_ready_read_i;
    logic [31:0] buf_data_i;
    logic [1:0]  grant_o;
    logic        abort_o;

    int testsRun    = 0;
    int testsFailed = 0;

    l1_miss_arbiter #(.BLOCK_WORDS(16)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .l1i_req_i(l1i_req_i), .l1i_reqBlock_i(l1i_reqBlock_i), .l1i_rw_i(l1i_rw_i),
        .l1i_write_i(l1i_write_i), .l1i_read_i(l1i_read_i),
        .l1i_add_i(l1i_add_i), .l1i_data_i(l1i_data_i),
        .l1i_uc_en_o(l1i_uc_en_o), .l1i_uc_write_ready_o(l1i_uc_write_ready_o),
        .l1i_uc_read_ready_o(l1i_uc_read_ready_o), .l1i_uc_data_o(l1i_uc_data_o),
        .l1d_req_i(l1d_req_i), .l1d_reqBlock_i(l1d_reqBlock_i), .l1d_rw_i(l1d_rw_i),
        .l1d_write_i(l1d_write_i), .l1d_read_i(l1d_read_i),
        .l1d_add_i(l1d_add_i), .l1d_data_i(l1d_data_i),
        .l1d_uc_en_o(l1d_uc_en_o), .l1d_uc_write_ready_o(l1d_uc_write_ready_o),
        .l1d_uc_read_ready_o(l1d_uc_read_ready_o), .l1d_uc_data_o(l1d_uc_data_o),
        .buf_req_o(buf_req_o), .buf_reqBlock_o(buf_reqBlock_o), .buf_rw_o(buf_rw_o),
        .buf_write_en_o(buf_write_en_o), .buf_read_ack_o(buf_read_ack_o),
        .buf_add_o(buf_add_o), .buf_data_o(buf_data_o),
        .buf_ready_write_i(buf_ready_write_i), .buf_ready_read_i(buf_ready_read_i),
        .buf_data_i(buf_data_i),
        .grant_o(grant_o), .abort_o(abort_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // One cycle of stimulus plus the outputs expected during that cycle.
    // iIn/dIn = {req, reqBlock, rw, write, read}; rdy = {readyWrite, readyRead};
    // en = {l1dEn, l1iEn}; ucRdy = {dWrRdy, dRdRdy, iWrRdy, iRdRdy}.
    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  iIn;
        logic [4:0]  dIn;
        logic [1:0]  rdy;
        logic [1:0]  grant;
        logic        abort;
        logic        bufReq;
        logic [1:0]  en;
        logic [23:0] add;
        logic [3:0]  ucRdy;
        logic [31:0] iData;
        logic [31:0] bufData;
    } vec_t;

    vec_t vecs[$];

    localparam logic [23:0] I_ADD  = 24'h000100;
    localparam logic [23:0] D_ADD  = 24'h000200;
    localparam logic [31:0] I_DATA = 32'h11111111;
    localparam logic [31:0] D_DATA = 32'h22222222;
    localparam logic [31:0] B_DATA = 32'hDEADBEEF;

    function automatic vec_t vIdle(string n, logic [4:0] i, logic [4:0] d, logic [1:0] r);
        vec_t v;
        v.name = n; v.rst = 1'b1; v.iIn = i; v.dIn = d; v.rdy = r;
        v.grant = 2'b00; v.abort = 1'b0; v.bufReq = 1'b0; v.en = 2'b11;
        v.add = '0; v.ucRdy = 4'b0000; v.iData = '0; v.bufData = '0;
        return v;
    endfunction

    function automatic vec_t vDrain(string n, logic [4:0] i, logic [4:0] d, logic [1:0] r,
                                    logic [1:0] g, logic ab);
        vec_t v;
        v = vIdle(n, i, d, r);
        v.grant = g; v.abort = ab;
        return v;
    endfunction

    function automatic vec_t vBusyI(string n, logic [4:0] i, logic [4:0] d, logic [1:0] r);
        vec_t v;
        v = vIdle(n, i, d, r);
        v.grant = 2'b01; v.bufReq = i[4]; v.en = 2'b01; v.add = I_ADD;
        v.ucRdy = {2'b00, r}; v.iData = B_DATA; v.bufData = I_DATA;
        return v;
    endfunction

    function automatic vec_t vBusyD(string n, logic [4:0] i, logic [4:0] d, logic [1:0] r);
        vec_t v;
        v = vIdle(n, i, d, r);
        v.grant = 2'b10; v.bufReq = d[4]; v.en = 2'b10; v.add = D_ADD;
        v.ucRdy = {r, 2'b00}; v.iData = '0; v.bufData = D_DATA;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset_i = v.rst;
        {l1i_req_i, l1i_reqBlock_i, l1i_rw_i, l1i_write_i, l1i_read_i} = v.iIn;
        {l1d_req_i, l1d_reqBlock_i, l1d_rw_i, l1d_write_i, l1d_read_i} = v.dIn;
        {buf_ready_write_i, buf_ready_read_i} = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v);
        chk({v.name, ".grant"},   32'(grant_o),   32'(v.grant));
        chk({v.name, ".abort"},   32'(abort_o),   32'(v.abort));
        chk({v.name, ".bufReq"},  32'(buf_req_o), 32'(v.bufReq));
        chk({v.name, ".en"},      32'({l1d_uc_en_o, l1i_uc_en_o}), 32'(v.en));
        chk({v.name, ".add"},     32'(buf_add_o), 32'(v.add));
        chk({v.name, ".ucRdy"},   32'({l1d_uc_write_ready_o, l1d_uc_read_ready_o,
                                       l1i_uc_write_ready_o, l1i_uc_read_ready_o}), 32'(v.ucRdy));
        chk({v.name, ".iData"},   l1i_uc_data_o, v.iData);
        chk({v.name, ".bufData"}, buf_data_o,    v.bufData);
    endtask

    task automatic setReqs(input logic rst, input logic [4:0] i, input logic [4:0] d,
                           input logic [1:0] r);
        vec_t v;
        v = vIdle("hand", i, d, r);
        v.rst = rst;
        applyStimulus(v);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        vec_t v;

        l1i_add_i = I_ADD; l1d_add_i = D_ADD;
        l1i_data_i = I_DATA; l1d_data_i = D_DATA;
        buf_data_i = B_DATA;
        setReqs(1'b0, 5'b0, 5'b0, 2'b00);

        v = vIdle("reset", 5'b0, 5'b0, 2'b00);
        v.rst = 1'b0;
        vecs.push_back(v);

        // Single-word read by L1I.
        vecs.push_back(vIdle ("rdReq",   5'b10000, 5'b0, 2'b00));
        vecs.push_back(vBusyI("rdWait",  5'b10000, 5'b0, 2'b01));
        vecs.push_back(vBusyI("rdBeat",  5'b10001, 5'b0, 2'b01));
        vecs.push_back(vDrain("rdDrain", 5'b00000, 5'b0, 2'b01, 2'b01, 1'b0));
        vecs.push_back(vIdle ("rdIdle",  5'b00000, 5'b0, 2'b00));

        // L1D block write with the buffer stalling every other cycle.
        vecs.push_back(vIdle("wrReq", 5'b0, 5'b11110, 2'b00));
        for (int k = 0; k < 32; k++) begin
            vecs.push_back(vBusyD($sformatf("wrBusy%0d", k), 5'b0, 5'b11110,
                                  (k % 2 == 1) ? 2'b10 : 2'b00));
        end
        vecs.push_back(vDrain("wrDrain", 5'b0, 5'b00000, 2'b00, 2'b10, 1'b0));
        vecs.push_back(vIdle ("wrIdle",  5'b0, 5'b00000, 2'b00));

        // Back-to-back ties of single reads; L1I drops after its second turn.
        vecs.push_back(vIdle ("tie1Req",   5'b10001, 5'b10001, 2'b01));
        vecs.push_back(vBusyI("tie1Busy",  5'b10001, 5'b10001, 2'b01));
        vecs.push_back(vDrain("tie1Drain", 5'b10001, 5'b10001, 2'b01, 2'b01, 1'b0));
        vecs.push_back(vIdle ("tie2Req",   5'b10001, 5'b10001, 2'b01));
`ifdef ARB_ROUND_ROBIN_EN
        vecs.push_back(vBusyD("tie2Busy",  5'b10001, 5'b10001, 2'b01));
        vecs.push_back(vDrain("tie2Drain", 5'b00000, 5'b10001, 2'b01, 2'b10, 1'b0));
`else
        vecs.push_back(vBusyI("tie2Busy",  5'b10001, 5'b10001, 2'b01));
        vecs.push_back(vDrain("tie2Drain", 5'b00000, 5'b10001, 2'b01, 2'b01, 1'b0));
`endif
        vecs.push_back(vIdle  ("tie3Req",   5'b00000, 5'b10001, 2'b01));
        vecs.push_back(vBusyD ("tie3Busy",  5'b00000, 5'b10001, 2'b01));
        vecs.push_back(vDrain ("tie3Drain", 5'b00000, 5'b00000, 2'b01, 2'b10, 1'b0));
        vecs.push_back(vIdle  ("tie3Idle",  5'b00000, 5'b00000, 2'b00));

        // L1I block read abandoned after five beats.
        vecs.push_back(vIdle("abReq", 5'b11001, 5'b0, 2'b01));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(vBusyI($sformatf("abBeat%0d", k), 5'b11001, 5'b0, 2'b01));
        end
        vecs.push_back(vBusyI("abDrop",  5'b00000, 5'b0, 2'b01));
        vecs.push_back(vDrain("abDrain", 5'b00000, 5'b0, 2'b01, 2'b01, 1'b1));
        vecs.push_back(vIdle ("abIdle",  5'b00000, 5'b0, 2'b00));

        // Full block read whose request drops on the 16th beat: no abort.
        vecs.push_back(vIdle("fbReq", 5'b11001, 5'b0, 2'b01));
        for (int k = 0; k < 15; k++) begin
            vecs.push_back(vBusyI($sformatf("fbBeat%0d", k), 5'b11001, 5'b0, 2'b01));
        end
        vecs.push_back(vBusyI("fbLast",  5'b01001, 5'b0, 2'b01));
        vecs.push_back(vDrain("fbDrain", 5'b00000, 5'b0, 2'b01, 2'b01, 1'b0));
        vecs.push_back(vIdle ("fbIdle",  5'b00000, 5'b0, 2'b00));

        tick();
        foreach (vecs[n]) begin
            applyStimulus(vecs[n]);
            #1;
            checkOutput(vecs[n]);
            tick();
        end

        // Reset in the middle of an L1D block read.
        setReqs(1'b1, 5'b0, 5'b11001, 2'b01);
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk("midBlk.grantBefore", 32'(grant_o), 32'(2'b10));
        setReqs(1'b0, 5'b0, 5'b11001, 2'b01);
        tick();
        chk("midBlk.grant",  32'(grant_o),   32'(2'b00));
        chk("midBlk.bufReq", 32'(buf_req_o), 32'(1'b0));
        chk("midBlk.en",     32'({l1d_uc_en_o, l1i_uc_en_o}), 32'(2'b11));
        chk("midBlk.abort",  32'(abort_o),   32'(1'b0));
        setReqs(1'b1, 5'b0, 5'b0, 2'b00);
        tick();
        chk("midBlk.abortAfter", 32'(abort_o), 32'(1'b0));
        chk("midBlk.grantIdle",  32'(grant_o), 32'(2'b00));
        setReqs(1'b1, 5'b10001, 5'b10001, 2'b00);
        tick();
        chk("midBlk.tieGrant", 32'(grant_o), 32'(2'b01));
        chk("midBlk.tieAdd",   32'(buf_add_o), 32'(I_ADD));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
